// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, ALU select codes,
// T-state encodings and the control-word field positions.
package cpu_pkg;

    localparam int OP_WIDTH = 4;
    localparam int NUM_T    = 6;
    localparam int T_W      = 3;

    // Opcodes (upper nibble of IR); 1010-1101 decode as NOP.
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MLT = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_STA = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_JZ  = 4'b1001;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // ALU select codes, shared with the ALU.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MLT = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    // T-state encodings.
    localparam logic [T_W-1:0] T0 = 3'd0;
    localparam logic [T_W-1:0] T1 = 3'd1;
    localparam logic [T_W-1:0] T2 = 3'd2;
    localparam logic [T_W-1:0] T3 = 3'd3;
    localparam logic [T_W-1:0] T4 = 3'd4;
    localparam logic [T_W-1:0] T5 = 3'd5;

    // Control-word bit positions.
    localparam int CW_PC_INC     = 0;
    localparam int CW_PC_EN      = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_EN     = 4;
    localparam int CW_RAM_WE     = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_EN      = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_EN       = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_EN     = 11;
    localparam int CW_FLAGS_LOAD = 12;
    localparam int CW_OUT_LOAD   = 13;
    localparam int CW_ALU_SEL    = 14;  // two bits: 15:14
    localparam int CW_W          = 16;

    // ALU select for an arithmetic opcode (00 for anything else).
    function automatic logic [1:0] alu_sel_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_MLT:  return ALU_MLT;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_t_state_counter.sv
// Mod-NUM_T T-state counter with hold, early terminate and synchronous clear.
import cpu_pkg::*;

module t_state_counter #(
    parameter int NUM_T = 6
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           adv,
    input  logic           last,
    output logic [T_W-1:0] t_state
);

    logic [T_W-1:0] t_state_reg;

    // Step to the next T-state, or wrap to T0 on the instruction's last step.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            t_state_reg <= T0;
        end else if (adv) begin
            if (last || (t_state_reg == T_W'(NUM_T - 1)))
                t_state_reg <= T0;
            else
                t_state_reg <= t_state_reg + 3'd1;
        end
    end

    assign t_state = t_state_reg;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded controller: fetch (T0,T1) then opcode/zf-decoded execute steps.
// Emits one control word per cycle; holds no datapath data.
import cpu_pkg::*;

module control_sequencer #(
    parameter int OP_WIDTH = 4,
    parameter int NUM_T    = 6
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                run,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zf,
    output logic                pc_inc,
    output logic                pc_en,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ir_load,
    output logic                ir_en,
    output logic                a_load,
    output logic                a_en,
    output logic                b_load,
    output logic [1:0]          alu_sel,
    output logic                alu_en,
    output logic                flags_load,
    output logic                out_load,
    output logic                hlt
);

    logic [T_W-1:0]  t_state;
    logic            halted_reg;
    logic            last;
    logic            arith;
    logic [CW_W-1:0] cw_next;
    logic [CW_W-1:0] cw;

    assign arith = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_MLT) || (opcode == OP_DIV);

    // Counter only moves while running and not halted.
    t_state_counter #(.NUM_T(NUM_T)) u_tsc (
        .clk     (clk),
        .clr_n   (clr_n),
        .adv     (run && !halted_reg),
        .last    (last),
        .t_state (t_state)
    );

    // Halt latches at the T2 edge of HLT and stays until reset.
    always_ff @(posedge clk) begin
        if (!clr_n)
            halted_reg <= 1'b0;
        else if (run && !halted_reg && (opcode == OP_HLT) && (t_state == T2))
            halted_reg <= 1'b1;
    end

    // Last T-state of the current instruction.
    always_comb begin
        last = 1'b0;
        if ((opcode == OP_LDA) || (opcode == OP_STA))
            last = (t_state == T3);
        else if (arith)
            last = (t_state == T5);
        else
            last = (t_state == T2);
    end

    // Control-word decode from (t_state, opcode, zf).
    always_comb begin
        cw_next = '0;
        case (t_state)
            T0: begin
                cw_next[CW_PC_EN]    = 1'b1;
                cw_next[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                cw_next[CW_RAM_EN]  = 1'b1;
                cw_next[CW_IR_LOAD] = 1'b1;
                cw_next[CW_PC_INC]  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_MLT, OP_DIV, OP_STA: begin
                        cw_next[CW_IR_EN]    = 1'b1;
                        cw_next[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw_next[CW_IR_EN]  = 1'b1;
                        cw_next[CW_A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        cw_next[CW_IR_EN]   = 1'b1;
                        cw_next[CW_PC_LOAD] = 1'b1;
                    end
                    OP_JZ: begin
                        cw_next[CW_IR_EN]   = zf;
                        cw_next[CW_PC_LOAD] = zf;
                    end
                    OP_OUT: begin
                        cw_next[CW_A_EN]     = 1'b1;
                        cw_next[CW_OUT_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                if (opcode == OP_LDA) begin
                    cw_next[CW_RAM_EN] = 1'b1;
                    cw_next[CW_A_LOAD] = 1'b1;
                end else if (opcode == OP_STA) begin
                    cw_next[CW_A_EN]  = 1'b1;
                    cw_next[CW_RAM_WE] = 1'b1;
                end else if (arith) begin
                    cw_next[CW_RAM_EN] = 1'b1;
                    cw_next[CW_B_LOAD] = 1'b1;
                end
            end
            T4: begin
                // ALU computes here and registers at the end of T4.
                if (arith)
                    cw_next[CW_ALU_SEL +: 2] = alu_sel_of(opcode);
            end
            T5: begin
                // Same select as T4 so the re-registered result is identical.
                if (arith) begin
                    cw_next[CW_ALU_SEL +: 2]  = alu_sel_of(opcode);
                    cw_next[CW_ALU_EN]        = 1'b1;
                    cw_next[CW_A_LOAD]        = 1'b1;
                    cw_next[CW_FLAGS_LOAD]    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Strobes are silent in reset, while frozen, and once halted.
    assign cw = (clr_n && run && !halted_reg) ? cw_next : '0;

    assign pc_inc     = cw[CW_PC_INC];
    assign pc_en      = cw[CW_PC_EN];
    assign pc_load    = cw[CW_PC_LOAD];
    assign mar_load   = cw[CW_MAR_LOAD];
    assign ram_en     = cw[CW_RAM_EN];
    assign ram_we     = cw[CW_RAM_WE];
    assign ir_load    = cw[CW_IR_LOAD];
    assign ir_en      = cw[CW_IR_EN];
    assign a_load     = cw[CW_A_LOAD];
    assign a_en       = cw[CW_A_EN];
    assign b_load     = cw[CW_B_LOAD];
    assign alu_en     = cw[CW_ALU_EN];
    assign flags_load = cw[CW_FLAGS_LOAD];
    assign out_load   = cw[CW_OUT_LOAD];
    assign alu_sel    = cw[CW_ALU_SEL +: 2];
    assign hlt        = halted_reg;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded controller for the 8-bit bus CPU. It sits directly upstream of the ALU and drives its sel and en inputs, plus every load/enable strobe on the shared bus.
- Runs a 6-state T-counter per instruction: fetch, then execute. Execute is decoded from the IR opcode nibble and the zero flag.
- Generates the control word each cycle. It holds no datapath data.

Parameters:
- OP_WIDTH, 4, opcode width (upper nibble of IR).
- NUM_T, 6, T-states per instruction (T0..T5).

Ports:
- clk  in  1  system clock, posedge.
- clr_n  in  1  synchronous active-low reset.
- run  in  1  high = sequence; low = freeze T-state, all strobes 0.
- opcode  in  4  IR[7:4].
- zf  in  1  zero flag from flags register.
- pc_inc  out  1  increment PC.
- pc_en  out  1  PC drives bus.
- pc_load  out  1  PC loads from bus (jump).
- mar_load  out  1  MAR loads from bus.
- ram_en  out  1  RAM drives bus.
- ram_we  out  1  RAM writes bus.
- ir_load  out  1  IR loads from bus.
- ir_en  out  1  IR[3:0] drives bus (zero-extended).
- a_load  out  1  A loads from bus.
- a_en  out  1  A drives bus.
- b_load  out  1  B loads from bus.
- alu_sel  out  2  ALU op: 00 ADD, 01 SUB, 10 MLT, 11 DIV.
- alu_en  out  1  ALU drives bus.
- flags_load  out  1  flags register captures ALU result.
- out_load  out  1  output register loads from bus.
- hlt  out  1  halted.

Behaviour:
- State: t_state (T0..T5) register plus halted register. Outputs are a combinational decode of (t_state, opcode, zf) and are forced to 0 while clr_n=0 or run=0. hlt = halted, which is not gated by run.
- Reset: at posedge with clr_n=0, t_state goes to T0 and halted is cleared. Reset mid-instruction aborts the instruction; only the T0 strobes appear in the cycle after release.
- Advance rule: at posedge with run=1 and halted=0, t_state goes to T0 if the current state is the instruction's last T-state, else t_state+1. With run=0 or halted=1, t_state holds.
- Fetch, all opcodes:
  - T0: pc_en, mar_load.
  - T1: ram_en, ir_load, pc_inc.
- Execute decode (opcode: steps; the last listed step returns to T0):
  - 0000 NOP: T2 no strobes.
  - 0001 LDA: T2 ir_en+mar_load; T3 ram_en+a_load.
  - 0010 ADD, 0011 SUB, 0100 MLT, 0101 DIV:
    - T2 ir_en+mar_load.
    - T3 ram_en+b_load.
    - T4 alu_sel valid, no bus strobes; the ALU registers its result at the end of T4.
    - T5 alu_sel held, alu_en+a_load+flags_load.
  - 0110 STA: T2 ir_en+mar_load; T3 a_en+ram_we.
  - 0111 LDI: T2 ir_en+a_load.
  - 1000 JMP: T2 ir_en+pc_load.
  - 1001 JZ: T2 ir_en+pc_load only if zf=1. Otherwise T2 has no strobes.
  - 1110 OUT: T2 a_en+out_load.
  - 1111 HLT: T2 sets halted at the T2 edge; t_state returns to T0 and freezes there.
  - 1010-1101: treated as NOP.
- alu_sel mapping: ADD→00, SUB→01, MLT→10, DIV→11. It is driven in T4 and T5 of arithmetic ops and is 00 elsewhere. It must be stable across both edges so the ALU re-registers an identical result at the T5 edge.
- Bus exclusivity: at most one of pc_en, ram_en, ir_en, a_en, alu_en is high in any cycle. This is a required invariant.
- Opcode is sampled combinationally. IR changes only at the T1 edge, so the decode is stable from T2 onward.
- run deasserted mid-instruction: state holds and strobes are 0. When run reasserts, the same T-state's strobes are reissued.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (NOP..HLT), ALU sel encodings (ADD/SUB/MLT/DIV, shared with the ALU), T-state encodings, NUM_T.
  - A control-word bit-index list so the sequencer and the bench share field positions.
- One natural sub-module: t_state_counter (mod-NUM_T counter with hold, early-terminate and sync clear). Decode stays in control_sequencer.

Test Plan:
- Reset then run=1 with opcode=0111 (LDI):
  - T0 pc_en+mar_load.
  - T1 ram_en+ir_load+pc_inc.
  - T2 ir_en+a_load.
  - Next cycle is T0 again; the instruction takes 3 cycles.
- opcode=0011 (SUB):
  - 6 cycles; alu_sel=01 in T4 and T5 only.
  - T5 asserts alu_en+a_load+flags_load.
  - Bus-exclusivity assertion holds in every cycle.
- opcode=1001 (JZ):
  - With zf=0: T2 has no strobes.
  - With zf=1: T2 has ir_en+pc_load.
  - Both cases take 3 cycles.
- opcode=1111 (HLT):
  - hlt rises after the T2 edge; all strobes stay 0 for 20 further cycles.
  - clr_n=0 for one edge clears hlt; T0 strobes appear on the first cycle after release.
- clr_n pulsed low during T4 of ADD:
  - Outputs are 0 in the reset cycle.
  - Next cycle is T0 with pc_en+mar_load; no alu_en or a_load ever appears for the aborted ADD.
- run dropped during T3 of LDA for 5 cycles:
  - All strobes are 0 and t_state holds.
  - On reassertion, ram_en+a_load is issued exactly once, then T0 follows.
